// File: rtl/seg_scan_ctrl_if.sv
// Load handshake and display-side bundle for seg_scan_ctrl.
// slave = the scan controller, master = whoever loads it and watches the pins.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_valid;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic                      load_ready;
    logic [3:0]                dig_code;
    logic                      dig_enable;
    logic [NUM_DIGITS-1:0]     dig_sel;
    logic                      frame_done;

    modport master (
        output load_valid, load_data,
        input  load_ready, dig_code, dig_enable, dig_sel, frame_done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, dig_code, dig_enable, dig_sel, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with tear-free double-buffered loading.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_en,
    seg_scan_ctrl_if.slave  bus
);
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW      = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] PRE_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        BLANK
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [DW-1:0]           active;
    logic [DW-1:0]           shadow;
    logic                    pending;

    logic [NUM_DIGITS-1:0]   sel_q;
    logic                    en_q;
    logic [3:0]              code_q;
    logic                    frame_q;

    logic                    copy;
    logic [DW-1:0]           next_active;
    logic [3:0]              digs [NUM_DIGITS];
    logic [IW-1:0]           enter_idx;
    logic [NUM_DIGITS-1:0]   enter_sel;
    logic [NUM_DIGITS-1:0]   lit_en;
    logic                    enter_en;
    logic [3:0]              enter_code;

    // Values the outputs take when a digit is about to light; the shadow is
    // forwarded here so the first digit after a swap already shows new data.
    always_comb begin
        copy = pending && ((state == IDLE) ||
                           (state == BLANK && cnt == BLANK_LAST &&
                            idx == IDX_LAST && scan_en));
        next_active = copy ? shadow : active;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digs[i] = next_active[4*i +: 4];
        end

        enter_idx = '0;
        if (state == BLANK && idx != IDX_LAST) begin
            enter_idx = idx + 1'b1;
        end
        enter_sel            = '1;
        enter_sel[enter_idx] = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
        begin : lz_blank
            logic zero_run;
            zero_run = 1'b1;
            lit_en   = '1;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                zero_run  = zero_run && (digs[i] == 4'b0000);
                lit_en[i] = ~zero_run;
            end
        end
`else
        lit_en = '1;
`endif

        enter_en   = lit_en[enter_idx];
        enter_code = digs[enter_idx];
    end

    // Scan FSM, load buffering and registered display outputs in one block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            active  <= '1;
            shadow  <= '0;
            pending <= 1'b0;
            sel_q   <= '1;
            en_q    <= 1'b0;
            code_q  <= 4'b0000;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;

            if (bus.load_valid && !pending) begin
                shadow  <= bus.load_data;
                pending <= 1'b1;
            end
            if (copy) begin
                active  <= shadow;
                pending <= 1'b0;
            end

            if (!scan_en) begin
                state <= IDLE;
                cnt   <= '0;
                idx   <= '0;
                sel_q <= '1;
                en_q  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state  <= ON;
                        cnt    <= '0;
                        idx    <= '0;
                        sel_q  <= enter_sel;
                        en_q   <= enter_en;
                        code_q <= enter_code;
                    end
                    ON: begin
                        if (cnt == PRE_LAST) begin
                            state <= BLANK;
                            cnt   <= '0;
                            sel_q <= '1;
                            en_q  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state   <= ON;
                            cnt     <= '0;
                            idx     <= enter_idx;
                            sel_q   <= enter_sel;
                            en_q    <= enter_en;
                            code_q  <= enter_code;
                            frame_q <= (idx == IDX_LAST);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        idx   <= '0;
                        sel_q <= '1;
                        en_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.load_ready = ~pending;
    assign bus.dig_sel    = sel_q;
    assign bus.dig_enable = en_q;
    assign bus.dig_code   = code_q;
    assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 4 lit cycles, 2 blank cycles).
// Each lit digit is checked for select, code, enable, frame_done, lit length and preceding gap.
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int PS = 4;
    localparam int BC = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic SUP = 1'b0;
`else
    localparam logic SUP = 1'b1;
`endif

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic scan_en = 1'b0;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scan_en (scan_en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] code;
        logic       en;
        logic       fd;
        int         len;
        int         gap;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   base   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic en);
        bus.load_valid = v;
        bus.load_data  = d;
        scan_en        = en;
    endtask

    task automatic pushExp(input logic [3:0] sel, input logic [3:0] code, input logic en,
                           input logic fd, input int len, input int gap);
        exp_t e;
        e.sel = sel; e.code = code; e.en = en; e.fd = fd; e.len = len; e.gap = gap;
        expq.push_back(e);
    endtask

    // One full frame: digit 0 carries the frame_done flag and gap given, the rest are steady-state.
    task automatic pushFrame(input logic [15:0] codes, input logic [3:0] ens,
                             input logic fd0, input int gap0);
        for (int i = 0; i < ND; i++) begin
            pushExp(~(4'b0001 << i), codes[4*i +: 4], ens[i], (i == 0) ? fd0 : 1'b0,
                    PS, (i == 0) ? gap0 : BC);
        end
    endtask

    task automatic gotoN(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    // Monitor: a lit period starts when dig_sel leaves all-ones; it is matched to the queue head.
    logic was_lit = 1'b0;
    int   cur_len = 0;
    int   exp_len = 0;
    int   gap     = 0;
    exp_t e_mon;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.dig_sel != 4'hF) begin
                if (!was_lit) begin
                    if (expq.size() == 0) begin
                        checkOutput("unexpected lit digit", {28'h0, bus.dig_sel}, 32'hF);
                        exp_len = -1;
                    end else begin
                        e_mon = expq.pop_front();
                        checkOutput("dig_sel", {28'h0, bus.dig_sel}, {28'h0, e_mon.sel});
                        checkOutput("dig_code", {28'h0, bus.dig_code}, {28'h0, e_mon.code});
                        checkOutput("dig_enable", {31'h0, bus.dig_enable}, {31'h0, e_mon.en});
                        checkOutput("frame_done", {31'h0, bus.frame_done}, {31'h0, e_mon.fd});
                        if (e_mon.gap >= 0) checkOutput("blank gap", gap, e_mon.gap);
                        exp_len = e_mon.len;
                    end
                    cur_len = 1;
                    was_lit = 1'b1;
                end else begin
                    cur_len++;
                    if (bus.frame_done) checkOutput("stray frame_done", 1, 0);
                end
            end else begin
                if (was_lit) begin
                    checkOutput("lit length", cur_len, exp_len);
                    gap     = 1;
                    was_lit = 1'b0;
                end else begin
                    gap++;
                end
                if (bus.frame_done) checkOutput("stray frame_done", 1, 0);
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc - base);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 16'h0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset dig_sel", {28'h0, bus.dig_sel}, 32'hF);
        checkOutput("reset dig_enable", {31'h0, bus.dig_enable}, 32'h0);
        checkOutput("reset dig_code", {28'h0, bus.dig_code}, 32'h0);
        checkOutput("reset frame_done", {31'h0, bus.frame_done}, 32'h0);
        checkOutput("reset load_ready", {31'h0, bus.load_ready}, 32'h1);
        reset = 1'b0;
        @(negedge clk);

        // Free-running dashes for two frames.
        base = cyc;
        pushFrame(16'hFFFF, 4'hF, 1'b0, -1);
        pushFrame(16'hFFFF, 4'hF, 1'b1, BC);
        applyStimulus(1'b0, 16'h0, 1'b1);

        // Mid-frame load shows up only in the next frame.
        gotoN(30);
        pushFrame(16'h4321, 4'hF, 1'b1, BC);
        applyStimulus(1'b1, 16'h4321, 1'b1);
        gotoN(31);
        checkOutput("load_ready after capture", {31'h0, bus.load_ready}, 32'h0);

        // Second offer held high while pending; it is taken just after the boundary.
        pushExp(4'b1110, 4'h5, 1'b1, 1'b1, PS, BC);
        pushExp(4'b1101, 4'h6, 1'b1, 1'b0, PS, BC);
        pushExp(4'b1011, 4'h7, 1'b1, 1'b0, 2, BC);
        applyStimulus(1'b1, 16'h8765, 1'b1);
        gotoN(48);
        checkOutput("load_ready held while pending", {31'h0, bus.load_ready}, 32'h0);
        gotoN(49);
        checkOutput("load_ready at frame boundary", {31'h0, bus.load_ready}, 32'h1);
        gotoN(50);
        checkOutput("load_ready after second capture", {31'h0, bus.load_ready}, 32'h0);
        applyStimulus(1'b0, 16'h8765, 1'b1);

        // Drop scan_en two cycles into digit 2, then restart from digit 0.
        gotoN(86);
        applyStimulus(1'b0, 16'h0, 1'b0);
        gotoN(87);
        checkOutput("dark dig_sel after disable", {28'h0, bus.dig_sel}, 32'hF);
        checkOutput("dark dig_enable after disable", {31'h0, bus.dig_enable}, 32'h0);
        gotoN(88);
        pushFrame(16'h8765, 4'hF, 1'b0, -1);
        applyStimulus(1'b0, 16'h0, 1'b1);

        gotoN(100);
        applyStimulus(1'b1, 16'h9999, 1'b1);
        gotoN(101);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("load_ready pending before reset", {31'h0, bus.load_ready}, 32'h0);

        // Asynchronous reset in the blank after digit 3.
        gotoN(111);
        #1 reset = 1'b1;
        #1;
        checkOutput("async reset dig_sel", {28'h0, bus.dig_sel}, 32'hF);
        checkOutput("async reset dig_enable", {31'h0, bus.dig_enable}, 32'h0);
        checkOutput("async reset dig_code", {28'h0, bus.dig_code}, 32'h0);
        checkOutput("async reset load_ready", {31'h0, bus.load_ready}, 32'h1);
        gotoN(113);
        reset = 1'b0;
        pushFrame(16'hFFFF, 4'hF, 1'b0, -1);
        pushExp(4'b1110, 4'hF, 1'b1, 1'b1, PS, BC);

        // Loads while idle are copied straight into the active buffer.
        gotoN(143);
        applyStimulus(1'b0, 16'h0, 1'b0);
        gotoN(145);
        applyStimulus(1'b1, 16'h0050, 1'b0);
        gotoN(146);
        applyStimulus(1'b0, 16'h0050, 1'b0);
        checkOutput("load_ready capture in idle", {31'h0, bus.load_ready}, 32'h0);
        gotoN(147);
        checkOutput("load_ready idle copy", {31'h0, bus.load_ready}, 32'h1);
        gotoN(148);
        pushFrame(16'h0050, {SUP, SUP, 1'b1, 1'b1}, 1'b0, -1);
        pushExp(4'b1110, 4'h0, 1'b1, 1'b1, PS, BC);
        applyStimulus(1'b0, 16'h0, 1'b1);

        gotoN(178);
        applyStimulus(1'b0, 16'h0, 1'b0);
        gotoN(179);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        gotoN(180);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        gotoN(182);
        pushFrame(16'h0000, {SUP, SUP, SUP, 1'b1}, 1'b0, -1);
        applyStimulus(1'b0, 16'h0, 1'b1);

        gotoN(205);
        applyStimulus(1'b0, 16'h0, 1'b0);
        gotoN(210);
        checkOutput("scoreboard drained", expq.size(), 0);
        checkOutput("final dig_sel dark", {28'h0, bus.dig_sel}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display that shares one 4-bit-code decoder.
- Feeds the shared decoder its 4-bit digit code plus enable, and drives the active-low digit-select lines.
- Sits between the processor's display output register and the decoder/board pins.
- Accepts new display contents via a valid/ready handshake and swaps them in only at frame boundaries, so no tearing.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 50000, clk cycles each digit is lit (>=2)
BLANK_CYCLES, 16, clk cycles all digits off between digits for anti-ghosting (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
scan_en  in  1  1 = scanning runs; 0 = display dark, FSM to IDLE
load_valid  in  1  new display data offered
load_data  in  4*NUM_DIGITS  digit codes; digit i = bits [4i+3:4i]; digit 0 = rightmost
load_ready  out  1  shadow buffer free
dig_code  out  4  code to shared decoder D input
dig_enable  out  1  to decoder Enable
dig_sel  out  NUM_DIGITS  active-low digit select, one-hot-low while lit
frame_done  out  1  1-cycle pulse at the end of each full scan frame

Behaviour:
- Reset (async, immediate) values:
  - dig_sel = all 1s; dig_enable = 0; dig_code = 4'b0000.
  - frame_done = 0; load_ready = 1.
  - active buffer = all digits 4'b1111 (dash); shadow empty; digit index = 0; prescale counter = 0; FSM = IDLE.
- Buffering:
  - Shadow register plus pending flag. load_ready = ~pending.
  - Handshake completes on a rising clk edge with load_valid & load_ready: shadow <= load_data, pending <= 1.
  - Data is held while load_ready = 0; load_valid may be held high.
  - Shadow copies to the active buffer only on the frame-boundary cycle, when the last digit's BLANK ends, or on any cycle in IDLE. In that cycle pending <= 0.
  - A load handshake cannot occur in the same cycle as that copy, because load_ready = 0 then.
- FSM states and transitions:
  - IDLE:
    - Outputs dark.
    - scan_en = 1 -> ON with index 0 and counter 0.
  - ON:
    - dig_sel[index] = 0, all others 1; dig_enable = 1; dig_code = active[index].
    - Counter counts 0..PRESCALE-1; at PRESCALE-1 -> BLANK with counter 0.
    - Lit for exactly PRESCALE cycles.
  - BLANK:
    - dig_sel all 1; dig_enable = 0; dig_code holds its last value.
    - Counter counts 0..BLANK_CYCLES-1. At the end:
      - if index = NUM_DIGITS-1: index <= 0, frame_done pulses for that one cycle, shadow copy occurs if pending;
      - otherwise index <= index+1.
    - Then -> ON.
- Frame period = NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
- scan_en = 0 in any state:
  - Next cycle: IDLE, outputs dark, index and counter reset to 0.
  - No frame_done pulse.
  - Re-enable restarts at digit 0.
- Outputs are registered; dig_sel/dig_enable change on the edge after the state change is decided. The decoder path adds no clock latency.
- Counter width = clog2(max(PRESCALE, BLANK_CYCLES)). Index width = clog2(NUM_DIGITS), with a minimum of 1.
- Index wrap at NUM_DIGITS-1 is explicit; no reliance on power-of-2 overflow.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - While in ON, digit index i is suppressed if active[i] = 4'b0000 and every higher digit j>i also holds 4'b0000.
  - Suppressed digit: dig_enable = 0 (decoder blanks), dig_sel still asserted, timing unchanged.
  - Digit 0 is never suppressed, so all-zero shows "0".
- Undefined: no suppression logic synthesised; every digit is enabled while in ON.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2.
- Reset, then scan_en=1, no load -> dig_sel sequence 1110,1111,1101,1111,1011,1111,0111,1111. Each select pattern lasts 4 cycles and each blank 2 cycles. dig_code=4'hF throughout; frame_done pulses every 24 cycles.
- Load 16'h4321 mid-frame -> load_ready falls the next cycle. The current frame still shows F,F,F,F. The next frame shows codes 1,2,3,4 on digits 0..3; load_ready returns to 1 at the boundary cycle.
- Second load_valid held while pending -> no capture, and load_valid stays high until the boundary. The captured value appears one frame later.
- scan_en dropped during ON of digit 2 -> next cycle dig_sel=1111 and dig_enable=0. Re-enable -> digit 0 lit for a full 4 cycles.
- Reset asserted mid-BLANK asynchronously -> outputs go to reset values without a clock edge, and pending is cleared.
- With LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3 and 2 have dig_enable=0, digits 1 and 0 show 5 and 0. Loading 16'h0000 -> only digit 0 is enabled, showing 0.
